c2_cfg_cell_array: RTL and testbench

- Parametrised, registered successor to the single C2 logic cell.
- LANES independent 4:1 mux cells. Each lane has configurable select-gating for s1 and s0, optional output inversion and a per-lane hold.
- Each lane output is registered, with a valid strobe.
- Configuration is loaded through a serial shadow chain and committed atomically. The block sits in the programmable-logic fabric, between routing and the cell output bus.

---
 rtl/c2_cfg_cell_array.sv | 138 +++++++++++++
 tb/tb_c2_cfg_cell_array.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/c2_cfg_cell_array.sv
// Array of LANES registered 4:1 mux cells (C2 successor) with per-lane select gating,
// inversion and hold, configured through a serial shadow chain with atomic commit.
module c2_cfg_cell_array #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned CFG_BITS = 6,
    parameter int unsigned CFG_W    = LANES * CFG_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] d00,
    input  logic [LANES-1:0] d01,
    input  logic [LANES-1:0] d10,
    input  logic [LANES-1:0] d11,
    input  logic [LANES-1:0] a1,
    input  logic [LANES-1:0] b1,
    input  logic [LANES-1:0] a0,
    input  logic [LANES-1:0] b0,
    input  logic             in_valid,
    output logic [LANES-1:0] out,
    output logic             out_valid,
    input  logic             cfg_shift,
    input  logic             cfg_sdi,
    input  logic             cfg_commit,
    output logic             cfg_sdo,
    output logic             cfg_full,
    output logic             cfg_err
);

    localparam int unsigned CntW = $clog2(CFG_W + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(CFG_W);

    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             err_q, err_d;
    logic [LANES-1:0] out_q, out_d;
    logic             out_valid_q;

    logic [LANES-1:0] lane_res;
    logic [LANES-1:0] lane_hold;

    // Per-lane combinational cell evaluated against the pre-edge active config.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [CFG_BITS-1:0] cfg;
        logic                s1;
        logic                s0;
        logic                mux;

        assign cfg = active_q[i*CFG_BITS +: CFG_BITS];

        always_comb begin
            s1 = 1'b0;
            unique case (cfg[1:0])
                2'b00:   s1 = a1[i] | b1[i];
                2'b01:   s1 = a1[i] & b1[i];
                2'b10:   s1 = a1[i] ^ b1[i];
                default: s1 = a1[i];
            endcase

            s0 = 1'b0;
            unique case (cfg[3:2])
                2'b00:   s0 = a0[i] & b0[i];
                2'b01:   s0 = a0[i] | b0[i];
                2'b10:   s0 = a0[i] ^ b0[i];
                default: s0 = a0[i];
            endcase

            mux = 1'b0;
            unique case ({s1, s0})
                2'b00:   mux = d00[i];
                2'b01:   mux = d01[i];
                2'b10:   mux = d10[i];
                default: mux = d11[i];
            endcase
        end

        assign lane_res[i]  = mux ^ cfg[4];
        assign lane_hold[i] = cfg[5];
    end

    always_comb begin
        shadow_d = shadow_q;
        if (cfg_shift) begin
            shadow_d = {shadow_q[CFG_W-2:0], cfg_sdi};
        end

        active_d = active_q;
        err_d    = err_q;
        if (cfg_commit) begin
            active_d = shadow_q;
            err_d    = ~full_q;
        end

        // A shift coinciding with a commit is the first bit of the next load.
        cnt_d = cnt_q;
        if (cfg_commit) begin
            cnt_d = cfg_shift ? CntW'(1) : '0;
        end else if (cfg_shift && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
        full_d = (cnt_d == CntMax);

        out_d = out_q;
        for (int i = 0; i < LANES; i++) begin
            if (in_valid && !lane_hold[i]) begin
                out_d[i] = lane_res[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= '0;
            active_q    <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            err_q       <= err_d;
            out_q       <= out_d;
            out_valid_q <= in_valid;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign cfg_sdo   = shadow_q[CFG_W-1];
    assign cfg_full  = full_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_c2_cfg_cell_array.sv
// Table-driven bench for c2_cfg_cell_array; lane outputs checked through an expected-value queue.
module tb_c2_cfg_cell_array;

    localparam int unsigned LANES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [LANES-1:0] d00, d01, d10, d11, a1, b1, a0, b0;
    logic             in_valid;
    logic [LANES-1:0] out;
    logic             out_valid;
    logic             cfg_shift, cfg_sdi, cfg_commit;
    logic             cfg_sdo, cfg_full, cfg_err;

    always #5 clk = ~clk;

    c2_cfg_cell_array #(.LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .d00        (d00),
        .d01        (d01),
        .d10        (d10),
        .d11        (d11),
        .a1         (a1),
        .b1         (b1),
        .a0         (a0),
        .b0         (b0),
        .in_valid   (in_valid),
        .out        (out),
        .out_valid  (out_valid),
        .cfg_shift  (cfg_shift),
        .cfg_sdi    (cfg_sdi),
        .cfg_commit (cfg_commit),
        .cfg_sdo    (cfg_sdo),
        .cfg_full   (cfg_full),
        .cfg_err    (cfg_err)
    );

    typedef struct packed {
        logic [3:0] d00, d01, d10, d11, a1, b1, a0, b0, exp;
    } vec_t;

    vec_t       tbl [15];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] exp_q [$];
    int         id_q [$];
    logic [3:0] mon_exp;
    int         mon_id;

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_vec(input vec_t v);
        d00 = v.d00; d01 = v.d01; d10 = v.d10; d11 = v.d11;
        a1  = v.a1;  b1  = v.b1;  a0  = v.a0;  b0  = v.b0;
    endtask

    task automatic drive(input int k);
        set_vec(tbl[k]);
        in_valid = 1'b1;
        exp_q.push_back(tbl[k].exp);
        id_q.push_back(k);
        tick();
        check($sformatf("out_valid vec %0d", k), {3'b0, out_valid}, 4'd1);
        in_valid = 1'b0;
    endtask

    // Shifts v[hi] first down to v[lo] last.
    task automatic shift_range(input logic [23:0] v, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            cfg_sdi   = v[i];
            cfg_shift = 1'b1;
            tick();
        end
        cfg_shift = 1'b0;
        cfg_sdi   = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    // Scoreboard: every valid output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected out_valid: got out %b, want no output", out);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_id  = id_q.pop_front();
                check($sformatf("out vec %0d", mon_id), out, mon_exp);
            end
        end
    end

    initial begin
        //              d00      d01      d10      d11      a1       b1       a0       b0       exp
        tbl[0]  = {4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
        tbl[1]  = {4'b1100, 4'b1010, 4'b0110, 4'b0101, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b1110};
        tbl[2]  = {4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1010, 4'b1010};
        tbl[3]  = {4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1001};
        tbl[4]  = {4'b0000, 4'b0001, 4'b0000, 4'b1110, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b1001};
        tbl[5]  = {4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0011};
        tbl[6]  = {4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110};
        tbl[7]  = {4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1101};
        tbl[8]  = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110};
        tbl[9]  = {4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1100};
        tbl[10] = {4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0101};
        tbl[11] = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0110};
        tbl[12] = {4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1101};
        tbl[13] = {4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
        tbl[14] = {4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001};

        rst = 1'b1;
        set_vec('0);
        in_valid   = 1'b0;
        cfg_shift  = 1'b0;
        cfg_sdi    = 1'b0;
        cfg_commit = 1'b0;
        tick();
        tick();
        check("reset out", out, 4'b0000);
        check("reset out_valid", {3'b0, out_valid}, 4'd0);
        check("reset cfg_full", {3'b0, cfg_full}, 4'd0);
        check("reset cfg_err", {3'b0, cfg_err}, 4'd0);
        check("reset cfg_sdo", {3'b0, cfg_sdo}, 4'd0);
        rst = 1'b0;

        // Classic C2 function under the all-zero config.
        for (int k = 0; k <= 3; k++) drive(k);
        tick();
        check("idle keeps out", out, 4'b1001);
        check("idle out_valid", {3'b0, out_valid}, 4'd0);

        // Full load: lane0 s1=AND, lane3 hold.
        shift_range(24'h800001, 23, 1);
        check("full after 23 shifts", {3'b0, cfg_full}, 4'd0);
        shift_range(24'h800001, 0, 0);
        check("full after 24 shifts", {3'b0, cfg_full}, 4'd1);
        check("sdo after load", {3'b0, cfg_sdo}, 4'd1);
        commit();
        check("full after commit", {3'b0, cfg_full}, 4'd0);
        check("err after full commit", {3'b0, cfg_err}, 4'd0);
        drive(4);

        // Partial load: 10 zero bits push old bit0 up to lane1 inv.
        shift_range(24'h000000, 9, 0);
        check("full after 10 shifts", {3'b0, cfg_full}, 4'd0);
        commit();
        check("err after partial commit", {3'b0, cfg_err}, 4'd1);
        drive(5);
        check("err sticky", {3'b0, cfg_err}, 4'd1);

        // Lane1 inv, lane2 hold.
        shift_range(24'h020400, 23, 0);
        check("full before hold commit", {3'b0, cfg_full}, 4'd1);
        drive(6);
        commit();
        check("err cleared", {3'b0, cfg_err}, 4'd0);
        check("full cleared", {3'b0, cfg_full}, 4'd0);
        for (int k = 7; k <= 11; k++) drive(k);

        // Commit + shift + sample in one cycle.
        shift_range(24'h000000, 23, 0);
        check("full before combo", {3'b0, cfg_full}, 4'd1);
        set_vec(tbl[12]);
        exp_q.push_back(tbl[12].exp);
        id_q.push_back(12);
        in_valid   = 1'b1;
        cfg_commit = 1'b1;
        cfg_shift  = 1'b1;
        cfg_sdi    = 1'b1;
        tick();
        in_valid   = 1'b0;
        cfg_commit = 1'b0;
        cfg_shift  = 1'b0;
        cfg_sdi    = 1'b0;
        check("combo out_valid", {3'b0, out_valid}, 4'd1);
        check("combo full", {3'b0, cfg_full}, 4'd0);
        check("combo err", {3'b0, cfg_err}, 4'd0);
        drive(13);
        shift_range(24'hFFFFFF, 21, 0);
        check("counter 23", {3'b0, cfg_full}, 4'd0);
        shift_range(24'hFFFFFF, 0, 0);
        check("counter 24", {3'b0, cfg_full}, 4'd1);

        // Reset mid-shift with a concurrent commit.
        commit();
        check("err after commit", {3'b0, cfg_err}, 4'd0);
        commit();
        check("err after empty commit", {3'b0, cfg_err}, 4'd1);
        shift_range(24'hFFFFFF, 11, 0);
        check("sdo before reset", {3'b0, cfg_sdo}, 4'd1);
        check("full mid-shift", {3'b0, cfg_full}, 4'd0);
        rst        = 1'b1;
        cfg_commit = 1'b1;
        cfg_shift  = 1'b1;
        cfg_sdi    = 1'b1;
        in_valid   = 1'b1;
        tick();
        check("rst out", out, 4'b0000);
        check("rst out_valid", {3'b0, out_valid}, 4'd0);
        check("rst cfg_sdo", {3'b0, cfg_sdo}, 4'd0);
        check("rst cfg_full", {3'b0, cfg_full}, 4'd0);
        check("rst cfg_err", {3'b0, cfg_err}, 4'd0);
        rst        = 1'b0;
        cfg_commit = 1'b0;
        cfg_shift  = 1'b0;
        cfg_sdi    = 1'b0;
        in_valid   = 1'b0;
        drive(14);
        tick();
        check("scoreboard drained", {3'b0, exp_q.size() == 0}, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
